scanout_fetcher: RTL and testbench

Prefetch stage between the SDRAM memory controller and the VGA video controller. Walks the frame buffer word by word, issues read requests on the local bus, buffers returned 16-bit words in a small FIFO, and unpacks each word into four 4-bit pixels delivered on the video controller's pixel strobe. It replaces the ad-hoc double-buffer in the top level with a flow-controlled, frame-synchronous fetch path.

---
 rtl/scanout_fetcher_pkg.sv | 11 +
 rtl/scanout_fetcher_if.sv | 11 +
 rtl/scanout_fetcher_sync_fifo.sv | 40 ++++
 rtl/scanout_fetcher.sv | 89 ++++++++
 tb/tb_scanout_fetcher.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/scanout_fetcher_pkg.sv
// scanout_fetcher_pkg: shared widths, fetch FSM states and nibble select for the scanout path
package scanout_fetcher_pkg;
    localparam int PIXEL_W = 4;
    localparam int WORD_W = 16;
    localparam int PIX_PER_WORD = 4;
    localparam int BUS_ADDR_W = 24;
    typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} fetch_state_t;
    function automatic logic [PIXEL_W-1:0] pick_nibble(input logic [WORD_W-1:0] word, input logic [1:0] sel);
        return word[PIXEL_W*int'(sel) +: PIXEL_W];
    endfunction
endpackage

// File: rtl/scanout_fetcher_if.sv
// scanout_fetcher_if: local-bus read port between the fetcher (master) and the SDRAM controller
interface scanout_fetcher_if;
    import scanout_fetcher_pkg::*;
    logic [BUS_ADDR_W-1:0] bus_addr;
    logic bus_ram_request;
    logic bus_n_write_enable;
    logic [WORD_W-1:0] bus_data_read;
    logic data_ready;
    modport master(output bus_addr, bus_ram_request, bus_n_write_enable, input bus_data_read, data_ready);
    modport slave(input bus_addr, bus_ram_request, bus_n_write_enable, output bus_data_read, data_ready);
endinterface

// File: rtl/scanout_fetcher_sync_fifo.sv
// sync_fifo: show-ahead word FIFO, same-cycle push/pop (push allowed into full when popping), sync flush
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic clk50M,
    input  logic reset,
    input  logic flush,
    input  logic push,
    input  logic [WIDTH-1:0] push_data,
    input  logic pop,
    output logic [WIDTH-1:0] head,
    output logic [$clog2(DEPTH):0] level,
    output logic empty,
    output logic full
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty = level == '0;
    assign full = level == (AW+1)'(DEPTH);
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head = mem[rd_ptr];
    always_ff @(posedge clk50M) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
    always_ff @(posedge clk50M) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/scanout_fetcher.sv
// scanout_fetcher: frame-synchronous SDRAM prefetch into a word FIFO, unpacked to 4-bit pixels
module scanout_fetcher import scanout_fetcher_pkg::*; #(
    parameter int FIFO_DEPTH = 16,
    parameter int FRAME_WORDS = 19200,
    parameter logic [BUS_ADDR_W-1:0] BASE_ADDR = 24'd0
) (
    input  logic clk50M,
    input  logic reset,
    input  logic frame_start,
    input  logic pix_ce,
    input  logic pix_visible,
    output logic [PIXEL_W-1:0] rgb_data,
    scanout_fetcher_if.master bus,
    output logic underflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int IDX_W = $clog2(FRAME_WORDS + 1) > 15 ? $clog2(FRAME_WORDS + 1) : 15;
    fetch_state_t state;
    logic [IDX_W-1:0] idx;
    logic [1:0] nib;
    logic [WORD_W-1:0] head;
    logic empty, full, take, push, pop, flush, last;
    assign take = pix_ce && pix_visible && !empty;
    assign pop = take && nib == 2'(PIX_PER_WORD - 1);
    assign push = state == REQ && bus.data_ready && !frame_start;
    // an in-flight read is never aborted: the restart waits for its data_ready
    assign flush = state == DRAIN ? bus.data_ready : state == REQ ? frame_start && bus.data_ready : frame_start;
    assign last = idx + IDX_W'(1) == IDX_W'(FRAME_WORDS);
    assign bus.bus_n_write_enable = 1'b1;
    sync_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk50M(clk50M),
        .reset(reset),
        .flush(flush),
        .push(push),
        .push_data(bus.bus_data_read),
        .pop(pop),
        .head(head),
        .level(fifo_level),
        .empty(empty),
        .full(full)
    );
    always_ff @(posedge clk50M) begin
        if (reset) begin
            state <= IDLE;
            idx <= '0;
            bus.bus_ram_request <= 1'b0;
            bus.bus_addr <= BASE_ADDR;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (frame_start) begin
                        state <= IDLE;
                        idx <= '0;
                    end else if (state == IDLE && idx < IDX_W'(FRAME_WORDS) && !full) begin
                        state <= REQ;
                        bus.bus_ram_request <= 1'b1;
                        bus.bus_addr <= BASE_ADDR + BUS_ADDR_W'(idx);
                    end
                end
                REQ: begin
                    if (bus.data_ready) begin
                        bus.bus_ram_request <= 1'b0;
                        idx <= frame_start ? '0 : idx + IDX_W'(1);
                        state <= !frame_start && last ? DONE : IDLE;
                    end else if (frame_start) state <= DRAIN;
                end
                DRAIN: begin
                    if (bus.data_ready) begin
                        bus.bus_ram_request <= 1'b0;
                        idx <= '0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
    always_ff @(posedge clk50M) begin
        if (reset) begin
            nib <= '0;
            rgb_data <= '0;
            underflow <= 1'b0;
        end else begin
            if (pix_ce) rgb_data <= take ? pick_nibble(head, nib) : '0;
            if (pix_ce && pix_visible && empty) underflow <= 1'b1;
            if (flush) nib <= '0;
            else if (take) nib <= nib + 2'd1;
        end
    end
endmodule

// File: tb/tb_scanout_fetcher.sv
// tb_scanout_fetcher: randomized scoreboard bench with a transaction-level frame/pixel model
module tb_scanout_fetcher;
    localparam int DEPTH = 4;
    localparam int FW = 8;
    localparam logic [23:0] BASE = 24'hFFFFFC;
    logic clk50M = 1'b0;
    logic reset = 1'b1;
    logic frame_start = 1'b0;
    logic pix_ce = 1'b0;
    logic pix_visible = 1'b0;
    logic [3:0] rgb_data;
    logic underflow;
    logic [2:0] fifo_level;
    int checks = 0;
    int errors = 0;
    logic [15:0] mq[$];
    logic [3:0] px_q[$];
    logic [23:0] aq[$];
    int mptr = 0;
    int nreq = 0;
    logic exp_uf = 1'b0;
    logic drain = 1'b0;
    logic req_n = 1'b0;
    logic rst_seen = 1'b0;
    int lat_min = 2;
    int lat_max = 2;
    int cnt = 0;
    int cur = 0;

    scanout_fetcher_if bus();

    scanout_fetcher #(.FIFO_DEPTH(DEPTH), .FRAME_WORDS(FW), .BASE_ADDR(BASE)) dut (
        .clk50M(clk50M),
        .reset(reset),
        .frame_start(frame_start),
        .pix_ce(pix_ce),
        .pix_visible(pix_visible),
        .rgb_data(rgb_data),
        .bus(bus),
        .underflow(underflow),
        .fifo_level(fifo_level)
    );

    always #10 clk50M = ~clk50M;

    function automatic logic [15:0] mem_word(input logic [23:0] a);
        return a == BASE ? 16'h4321 : a[15:0] ^ 16'hA5C3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic restart_frame();
        mq.delete();
        mptr = 0;
        aq.delete();
        for (int i = 0; i < FW; i++) aq.push_back(BASE + 24'(i));
        nreq = 0;
    endtask

    task automatic step(input logic ce, input int vis_pct);
        @(negedge clk50M);
        frame_start = 1'b0;
        pix_ce = ce;
        pix_visible = int'($urandom_range(99)) < vis_pct;
    endtask

    task automatic run(input int n, input int vis_pct);
        for (int i = 0; i < n; i++) step(i % 2 == 0, vis_pct);
    endtask

    task automatic pix(input logic vis);
        step(1'b1, vis ? 100 : 0);
        step(1'b0, 0);
    endtask

    task automatic fstart();
        @(negedge clk50M);
        frame_start = 1'b1;
        pix_ce = 1'b0;
        pix_visible = 1'b0;
    endtask

    task automatic wait_req(input logic lvl, input string nm);
        int n = 0;
        while (bus.bus_ram_request !== lvl && n < 400) begin
            step(1'b0, 0);
            n++;
        end
        chk(nm, 32'(bus.bus_ram_request), 32'(lvl));
    endtask

    // memory: answers each request after a random latency with a one-cycle data_ready
    initial forever begin
        @(negedge clk50M);
        bus.data_ready = 1'b0;
        if (reset) cnt = 0;
        else if (bus.bus_ram_request) begin
            if (cnt == 0) cur = int'($urandom_range(lat_max, lat_min));
            if (cnt >= cur) begin
                bus.data_ready = 1'b1;
                bus.bus_data_read = mem_word(bus.bus_addr);
                cnt = 0;
            end else cnt++;
        end
    end

    // request monitor: each new request must carry the next expected frame address
    initial forever begin
        @(negedge clk50M);
        if (bus.bus_ram_request && !req_n) begin
            nreq++;
            if (aq.size() == 0) chk("request_count", 32'(nreq), 32'(FW));
            else chk("bus_addr", 32'(bus.bus_addr), 32'(aq.pop_front()));
            chk("n_write_enable", 32'(bus.bus_n_write_enable), 32'd1);
        end
        req_n = bus.bus_ram_request;
    end

    // reference model: kept words, nibble order, sticky underflow, frame restarts
    initial forever begin
        @(posedge clk50M);
        if (reset) begin
            restart_frame();
            px_q.delete();
            px_q.push_back(4'h0);
            exp_uf = 1'b0;
            drain = 1'b0;
            rst_seen = 1'b1;
        end else begin
            if (pix_ce) begin
                if (pix_visible && mq.size() > 0) begin
                    px_q.push_back(mq[0][mptr*4 +: 4]);
                    if (mptr == 3) begin
                        void'(mq.pop_front());
                        mptr = 0;
                    end else mptr++;
                end else begin
                    px_q.push_back(4'h0);
                    if (pix_visible) exp_uf = 1'b1;
                end
            end
            if (req_n && bus.data_ready) begin
                if (frame_start || drain) begin
                    restart_frame();
                    drain = 1'b0;
                end else mq.push_back(bus.bus_data_read);
            end else if (frame_start) begin
                if (req_n) drain = 1'b1;
                else restart_frame();
            end
        end
    end

    // output monitor
    initial forever begin
        @(posedge clk50M);
        #1;
        chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
        chk("underflow", 32'(underflow), 32'(exp_uf));
        if (px_q.size() > 0) chk("rgb_data", 32'(rgb_data), 32'(px_q.pop_front()));
        if (rst_seen) begin
            chk("reset_request", 32'(bus.bus_ram_request), 32'd0);
            chk("reset_addr", 32'(bus.bus_addr), 32'(BASE));
            rst_seen = 1'b0;
        end
    end

    initial begin
        repeat (3) step(1'b0, 0);
        reset = 1'b0;
        run(200, 100);
        chk("done_request_low", 32'(bus.bus_ram_request), 32'd0);
        chk("frame_request_count", 32'(nreq), 32'(FW));
        fstart();
        repeat (40) step(1'b0, 0);
        chk("full_level", 32'(fifo_level), 32'(DEPTH));
        chk("full_request_low", 32'(bus.bus_ram_request), 32'd0);
        lat_min = 5;
        lat_max = 5;
        repeat (4) pix(1'b1);
        step(1'b0, 0);
        chk("refill_request", 32'(bus.bus_ram_request), 32'd1);
        fstart();
        step(1'b0, 0);
        chk("drain_request_held", 32'(bus.bus_ram_request), 32'd1);
        wait_req(1'b0, "drain_complete");
        chk("drain_level", 32'(fifo_level), 32'd0);
        wait_req(1'b1, "restart_request");
        chk("restart_addr", 32'(bus.bus_addr), 32'(BASE));
        reset = 1'b1;
        step(1'b0, 0);
        reset = 1'b0;
        chk("rst_mid_req_request", 32'(bus.bus_ram_request), 32'd0);
        chk("rst_mid_req_level", 32'(fifo_level), 32'd0);
        chk("rst_mid_req_rgb", 32'(rgb_data), 32'd0);
        chk("rst_mid_req_underflow", 32'(underflow), 32'd0);
        lat_min = 200;
        lat_max = 200;
        run(600, 100);
        chk("stall_underflow", 32'(underflow), 32'd1);
        lat_min = 0;
        lat_max = 4;
        run(300, 100);
        chk("underflow_sticky", 32'(underflow), 32'd1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) fstart();
            else step(i % 2 == 0, 80);
        end
        run(200, 100);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
